// File: rtl/wallace_mac_pkg.sv
// rtl/wallace_mac_pkg.sv - shared types and constants for the Wallace MAC accumulator
package wallace_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } mac_state_t;

    localparam int ACC_W_DEF     = 24;
    localparam int MAX_TERMS_DEF = 256;
    localparam int PROD_W        = 16;

endpackage

// File: rtl/wallace_mac_accumulator_acc_sat_add.sv
// rtl/wallace_mac_accumulator_acc_sat_add.sv - unsigned saturating adder, accumulator plus product
module acc_sat_add
    import wallace_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              sat
);

    logic [ACC_W:0] wide_sum;

    // One extra bit catches the carry out; a carry means clamp to all ones
    always_comb begin
        wide_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};
        sat      = wide_sum[ACC_W];
        sum      = wide_sum[ACC_W] ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
    end

endmodule

// File: rtl/wallace_mac_accumulator.sv
// rtl/wallace_mac_accumulator.sv - saturating dot-product accumulator with held valid/ready result
module wallace_mac_accumulator
    import wallace_mac_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_result,
    output logic [CNT_W-1:0]  out_terms,
    output logic              out_ovf,
    output logic              out_forced
);

    mac_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [ACC_W-1:0] sat_sum;
    logic             sat;
    logic [CNT_W-1:0] cnt_next;
    logic             hit_limit;
    logic             accept;

    acc_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc     (acc),
        .product (in_product),
        .sum     (sat_sum),
        .sat     (sat)
    );

    assign in_ready  = (state != DRAIN);
    assign out_valid = (state == DRAIN);
    assign accept    = in_valid && in_ready;
    assign cnt_next  = cnt + CNT_W'(1);
    assign hit_limit = (cnt_next == CNT_W'(MAX_TERMS));

    // Run FSM: accumulate accepted beats, latch the result on close, hold it until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            out_result <= '0;
            out_terms  <= '0;
            out_ovf    <= 1'b0;
            out_forced <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc <= sat_sum;
                        cnt <= cnt_next;
                        ovf <= ovf | sat;
                        if (in_last || hit_limit) begin
                            out_result <= sat_sum;
                            out_terms  <= cnt_next;
                            out_ovf    <= ovf | sat;
                            out_forced <= hit_limit && !in_last;
                            state      <= DRAIN;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        state      <= IDLE;
                        acc        <= '0;
                        cnt        <= '0;
                        ovf        <= 1'b0;
                        out_forced <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
